// File: rtl/a5_init_sequencer.sv
// A5/1 initialisation sequencer: clears three external LFSRs, serially loads key and
// frame number, runs majority-clocked mixing, then streams keystream bits with backpressure.
module a5_init_sequencer #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 101,
  parameter int KS_BITS    = 228
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [2:0]            lfsr_clk_bit,
  input  logic [2:0]            lfsr_q,
  output logic                  lfsr_reset_n,
  output logic                  lfsr_d,
  output logic [2:0]            lfsr_clk_en,
  output logic                  busy,
  output logic                  ks_bit,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic                  done
);

  localparam int M1    = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
  localparam int M2    = (MIX_CYCLES > KS_BITS) ? MIX_CYCLES : KS_BITS;
  localparam int MAXN  = (M1 > M2) ? M1 : M2;
  localparam int CW    = $clog2(MAXN);
  localparam int CNT_W = (CW < 8) ? 8 : CW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    KEY   = 3'd2,
    FRAME = 3'd3,
    MIX   = 3'd4,
    KS    = 3'd5
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [KEY_BITS-1:0]     key_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [KEY_BITS-1:0]     key_sh;
  logic [FRAME_BITS-1:0]   frame_sh;
  logic                    maj;
  logic [2:0]              maj_en;

  // Shifting instead of bit-selecting keeps the counter free to be wider than the index.
  assign key_sh   = key_q >> cnt;
  assign frame_sh = frame_q >> cnt;

  assign maj = (lfsr_clk_bit[0] & lfsr_clk_bit[1]) |
               (lfsr_clk_bit[0] & lfsr_clk_bit[2]) |
               (lfsr_clk_bit[1] & lfsr_clk_bit[2]);

  for (genvar i = 0; i < 3; i++) begin : g_maj
    assign maj_en[i] = lfsr_clk_bit[i] ~^ maj;
  end

  assign ks_bit = ^lfsr_q;

  always_comb begin
    lfsr_clk_en = 3'b000;
    lfsr_d      = 1'b0;
    case (state)
      KEY: begin
        lfsr_clk_en = 3'b111;
        lfsr_d      = key_sh[0];
      end
      FRAME: begin
        lfsr_clk_en = 3'b111;
        lfsr_d      = frame_sh[0];
      end
      MIX:     lfsr_clk_en = maj_en;
      KS:      lfsr_clk_en = ks_ready ? maj_en : 3'b000;
      default: lfsr_clk_en = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      key_q        <= '0;
      frame_q      <= '0;
      busy         <= 1'b0;
      ks_valid     <= 1'b0;
      done         <= 1'b0;
      lfsr_reset_n <= 1'b1;
    end else begin
      done         <= 1'b0;
      lfsr_reset_n <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            key_q        <= key;
            frame_q      <= frame;
            cnt          <= '0;
            busy         <= 1'b1;
            lfsr_reset_n <= 1'b0;
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= KEY;
        end
        KEY: begin
          if (cnt == CNT_W'(KEY_BITS - 1)) begin
            cnt   <= '0;
            state <= FRAME;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FRAME: begin
          if (cnt == CNT_W'(FRAME_BITS - 1)) begin
            cnt   <= '0;
            state <= MIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MIX: begin
          if (cnt == CNT_W'(MIX_CYCLES - 1)) begin
            cnt      <= '0;
            ks_valid <= 1'b1;
            state    <= KS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        KS: begin
          if (ks_ready) begin
            if (cnt == CNT_W'(KS_BITS - 1)) begin
              cnt      <= '0;
              ks_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt      <= '0;
          busy     <= 1'b0;
          ks_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a5_init_sequencer.sv
// Bench for a5_init_sequencer: three A5/1 LFSRs hang off the DUT, a session-level model
// predicts every output each cycle, and directed sessions pin timing, loading and keystream.
module tb_a5_init_sequencer;

  localparam int KEY_BITS   = 64;
  localparam int FRAME_BITS = 22;
  localparam int MIX_CYCLES = 101;
  localparam int KS_BITS    = 228;
  localparam int T_FRAME0   = 1 + KEY_BITS;
  localparam int T_MIX0     = T_FRAME0 + FRAME_BITS;
  localparam int T_KS       = T_MIX0 + MIX_CYCLES;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic [KEY_BITS-1:0]   key = '0;
  logic [FRAME_BITS-1:0] frame = '0;
  logic [2:0]            lfsr_clk_bit;
  logic [2:0]            lfsr_q;
  logic                  lfsr_reset_n;
  logic                  lfsr_d;
  logic [2:0]            lfsr_clk_en;
  logic                  busy;
  logic                  ks_bit;
  logic                  ks_valid;
  logic                  ks_ready = 1'b1;
  logic                  done;

  always #5 clk = ~clk;

  a5_init_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .key          (key),
    .frame        (frame),
    .lfsr_clk_bit (lfsr_clk_bit),
    .lfsr_q       (lfsr_q),
    .lfsr_reset_n (lfsr_reset_n),
    .lfsr_d       (lfsr_d),
    .lfsr_clk_en  (lfsr_clk_en),
    .busy         (busy),
    .ks_bit       (ks_bit),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .done         (done)
  );

  // The three A5/1 registers driven by the sequencer.
  logic [18:0] r1 = '0;
  logic [21:0] r2 = '0;
  logic [22:0] r3 = '0;
  always @(posedge clk) begin
    if (!lfsr_reset_n) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
    end else begin
      if (lfsr_clk_en[0]) r1 <= {r1[17:0], r1[18]^r1[17]^r1[16]^r1[13]^lfsr_d};
      if (lfsr_clk_en[1]) r2 <= {r2[20:0], r2[21]^r2[20]^lfsr_d};
      if (lfsr_clk_en[2]) r3 <= {r3[21:0], r3[22]^r3[21]^r3[20]^r3[7]^lfsr_d};
    end
  end

  logic       ovr_en = 1'b0;
  logic [2:0] ovr_code = 3'b011;
  logic       bp_en = 1'b0;
  assign lfsr_clk_bit = ovr_en ? ovr_code : {r3[10], r2[10], r1[8]};
  assign lfsr_q       = {r3[22], r2[21], r1[18]};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] maj_en(input logic [2:0] b);
    int   ones;
    logic m;
    logic [2:0] r;
    ones = int'(b[0]) + int'(b[1]) + int'(b[2]);
    m = (ones >= 2);
    for (int i = 0; i < 3; i++) r[i] = (b[i] == m);
    return r;
  endfunction

  // Reference A5/1 keystream computed from scratch for a given key and frame.
  function automatic logic [KS_BITS-1:0] a5_ref(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic [KS_BITS-1:0] ks;
    logic d, m;
    a = '0; b = '0; c = '0; ks = '0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) d = k[i];
      else        d = f[i-64];
      a = {a[17:0], a[18]^a[17]^a[16]^a[13]^d};
      b = {b[20:0], b[21]^b[20]^d};
      c = {c[21:0], c[22]^c[21]^c[20]^c[7]^d};
    end
    for (int i = 0; i < MIX_CYCLES + KS_BITS; i++) begin
      if (i >= MIX_CYCLES) ks[i-MIX_CYCLES] = a[18]^b[21]^c[22];
      m = (a[8]&b[10]) | (a[8]&c[10]) | (b[10]&c[10]);
      if (a[8] == m)  a = {a[17:0], a[18]^a[17]^a[16]^a[13]};
      if (b[10] == m) b = {b[20:0], b[21]^b[20]};
      if (c[10] == m) c = {c[21:0], c[22]^c[21]^c[20]^c[7]};
    end
    return ks;
  endfunction

  // Session model: time since accept, then handshake count once keystream starts.
  logic                  m_act = 1'b0;
  logic                  m_done = 1'b0;
  int                    m_t = 0;
  int                    m_hs = 0;
  logic [KEY_BITS-1:0]   m_key = '0;
  logic [FRAME_BITS-1:0] m_frame = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_act = 1'b0; m_done = 1'b0; m_t = 0; m_hs = 0; m_key = '0; m_frame = '0;
    end else begin
      m_done = 1'b0;
      if (m_act) begin
        if (m_t < T_KS) m_t++;
        else if (ks_ready) begin
          m_hs++;
          if (m_hs == KS_BITS) begin m_act = 1'b0; m_done = 1'b1; end
        end
      end else if (start) begin
        m_act = 1'b1; m_t = 0; m_hs = 0; m_key = key; m_frame = frame;
      end
    end
  end

  // Input drivers, updated just after each rising edge.
  int bp_i = 0;
  logic [2:0] codes [8] = '{3'b011, 3'b100, 3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
  always @(posedge clk) begin
    #1;
    if (m_act && m_t >= T_MIX0 && m_t < T_MIX0 + 8) ovr_code = codes[m_t - T_MIX0];
    else                                            ovr_code = 3'b011;
    ks_ready = bp_en ? ((bp_i % 4 == 0) || (bp_i % 4 == 3)) : 1'b1;
    bp_i++;
  end

  // Per-cycle compare and session statistics.
  logic chk_en = 1'b0;
  logic prev_busy = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0, prev_bit = 1'b0;
  int   rel = 0, first_valid_rel = -1, done_rel = -1, done_cnt = 0, hs_dut = 0;
  int   d_ones = 0, d_first_rel = -1, rst_low = 0, rst_rel = -1;
  int   run = 0, run_start = 0, en7_max = 0, en7_start = -1;
  logic [2:0] en_at87 = '0, en_at88 = '0;
  logic cap [$];

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] e_en;
      logic       e_d;
      if (busy && !prev_busy) begin
        rel = 0; first_valid_rel = -1; done_rel = -1; hs_dut = 0; cap.delete();
        d_ones = 0; d_first_rel = -1; rst_low = 0; rst_rel = -1;
        run = 0; en7_max = 0; en7_start = -1;
      end else rel++;

      e_en = 3'b000;
      e_d  = 1'b0;
      if (m_act && m_t >= 1) begin
        if (m_t < T_MIX0)   e_en = 3'b111;
        else if (m_t < T_KS) e_en = maj_en(lfsr_clk_bit);
        else                 e_en = ks_ready ? maj_en(lfsr_clk_bit) : 3'b000;
        if (m_t <= KEY_BITS)    e_d = m_key[m_t-1];
        else if (m_t < T_MIX0) e_d = m_frame[m_t-T_FRAME0];
      end
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("ks_valid", ks_valid, m_act && m_t == T_KS);
      chk("lfsr_reset_n", lfsr_reset_n, !(m_act && m_t == 0));
      chk("lfsr_clk_en", lfsr_clk_en, e_en);
      chk("lfsr_d", lfsr_d, e_d);
      chk("ks_bit", ks_bit, ^lfsr_q);
      if (prev_stall && ks_valid) chk("ks_bit_stable", ks_bit, prev_bit);

      if (ks_valid && !prev_valid) first_valid_rel = rel;
      if (ks_valid && ks_ready) begin hs_dut++; cap.push_back(ks_bit); end
      if (done) begin
        done_rel = rel; done_cnt++;
        chk("handshakes_before_done", hs_dut, KS_BITS);
      end
      if (lfsr_d) begin d_ones++; if (d_first_rel < 0) d_first_rel = rel; end
      if (!lfsr_reset_n) begin rst_low++; rst_rel = rel; end
      if (lfsr_clk_en == 3'b111) begin
        if (run == 0) run_start = rel;
        run++;
        if (run > en7_max) begin en7_max = run; en7_start = run_start; end
      end else run = 0;
      if (rel == 87) en_at87 = lfsr_clk_en;
      if (rel == 88) en_at88 = lfsr_clk_en;

      prev_busy  = busy;
      prev_valid = ks_valid;
      prev_stall = ks_valid && !ks_ready;
      prev_bit   = ks_bit;
    end
  end

  task automatic start_session(input logic [63:0] k, input logic [21:0] f);
    key = k; frame = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    chk({name, "_done_seen"}, got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_cap(input string name, input logic [KS_BITS-1:0] exp);
    int bad;
    bad = 0;
    chk({name, "_count"}, cap.size(), KS_BITS);
    for (int i = 0; i < cap.size() && i < KS_BITS; i++) if (cap[i] !== exp[i]) bad++;
    chk({name, "_bit_mismatches"}, bad, 0);
  endtask

  function automatic logic [63:0] first64(input logic [KS_BITS-1:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v = {v[62:0], b[i]};
    return v;
  endfunction

  localparam logic [63:0] KAT_KEY  = 64'hEFCDAB8967452312;
  localparam logic [21:0] KAT_FRM  = 22'h134;
  localparam logic [63:0] KAT_HEAD = 64'h534EAA582FE8151A;

  initial begin
    logic [KS_BITS-1:0] ref_ks;
    logic [KS_BITS-1:0] got_ks;
    int dc;

    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ks_valid", ks_valid, 1'b0);
    chk("rst_clk_en", lfsr_clk_en, 3'b000);
    chk("rst_lfsr_d", lfsr_d, 1'b0);
    chk("rst_lfsr_reset_n", lfsr_reset_n, 1'b1);
    @(posedge clk); #1;

    // Model pin: reference keystream head against the published A5/1 vector.
    ref_ks = a5_ref(KAT_KEY, KAT_FRM);
    chk("ref_model_head", first64(ref_ks), KAT_HEAD);

    // Zero session: timing and all-zero keystream.
    start_session('0, '0);
    wait_done("zero");
    chk("zero_first_valid_cycle", first_valid_rel, 188);
    chk("zero_done_cycle", done_rel, 416);
    check_cap("zero_ks", '0);

    // Load sequence and majority truth table (clock bits overridden).
    ovr_en = 1'b1;
    start_session(64'h1, 22'h0);
    wait_done("load");
    ovr_en = 1'b0;
    chk("load_d_ones", d_ones, 1);
    chk("load_d_first_cycle", d_first_rel, 1);
    chk("load_en7_run", en7_max, 86);
    chk("load_en7_run_start", en7_start, 1);
    chk("load_rst_low_cycles", rst_low, 1);
    chk("load_rst_low_cycle", rst_rel, 0);
    chk("maj_011", en_at87, 3'b011);
    chk("maj_100", en_at88, 3'b011);

    // Backpressure 1,0,0,1 through the whole session.
    bp_en = 1'b1;
    start_session(64'h0123456789ABCDEF, 22'h2A5A5);
    wait_done("bp");
    bp_en = 1'b0;
    check_cap("bp_ks", a5_ref(64'h0123456789ABCDEF, 22'h2A5A5));

    // Known answer, with start and new inputs held high mid-session.
    start_session(KAT_KEY, KAT_FRM);
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1; key = ~KAT_KEY; frame = ~KAT_FRM;
    repeat (100) @(posedge clk);
    #1 start = 1'b0;
    wait_done("kat");
    check_cap("kat_ks", ref_ks);
    got_ks = '0;
    for (int i = 0; i < cap.size() && i < KS_BITS; i++) got_ks[i] = cap[i];
    chk("kat_head", first64(got_ks), KAT_HEAD);

    // Reset mid-MIX aborts without done; next session completes.
    dc = done_cnt;
    start_session(KAT_KEY, KAT_FRM);
    for (int c = 0; c < 500; c++) begin
      if (m_act && m_t == 100) break;
      @(posedge clk); #1;
    end
    chk("reached_mix", m_t, 100);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done_pulse", done_cnt, dc);
    start_session(KAT_KEY, KAT_FRM);
    wait_done("after_abort");
    check_cap("after_abort_ks", ref_ks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
